// File: rtl/cpu_pipe_pkg.sv
// Shared MEM/WB pipeline bus layout, used by the MEM/WB register, the
// hazard/forward unit and the write-back register file.
package cpu_pipe_pkg;

    localparam int MEMWB_W  = 72;

    localparam int RW_BIT   = 0;
    localparam int M2R_BIT  = 1;
    localparam int WREG_LSB = 2;
    localparam int WREG_MSB = 7;
    localparam int ALU_LSB  = 8;
    localparam int ALU_MSB  = 39;
    localparam int DM_LSB   = 40;
    localparam int DM_MSB   = 71;

    localparam int REG_ZERO = 0;

    // Field view of the bus; member order reproduces the bit positions above.
    typedef struct packed {
        logic [DM_MSB-DM_LSB:0]     dm_out;
        logic [ALU_MSB-ALU_LSB:0]   alu_out;
        logic [WREG_MSB-WREG_LSB:0] write_reg;
        logic                       mem_to_reg;
        logic                       reg_write;
    } memwb_t;

endpackage

// File: rtl/wb_unpack.sv
// Combinational decode of the MEM/WB bus into write-back data, index and
// enable. Register 0 and the reserved writeReg[5] encoding never enable a write.
module wb_unpack
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic [MEMWB_W-1:0] i_bus,
    output logic [DATA_W-1:0]  o_wdata,
    output logic [ADDR_W-1:0]  o_widx,
    output logic               o_we
);

    memwb_t                     w_bus;
    logic [WREG_MSB-WREG_LSB:0] w_wreg;
    logic                       w_reserved;

    assign w_bus      = memwb_t'(i_bus);
    assign w_wreg     = w_bus.write_reg;
    assign w_reserved = w_wreg[WREG_MSB-WREG_LSB];

    assign o_widx  = w_wreg[ADDR_W-1:0];
    assign o_wdata = w_bus.mem_to_reg ? w_bus.dm_out : w_bus.alu_out;
    assign o_we    = w_bus.reg_write && !w_reserved &&
                     (o_widx != ADDR_W'(REG_ZERO));

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: commits MEM/WB results, serves two ID read
// ports with same-cycle bypass, and keeps a forwarding record and retire count.
module wb_regfile
    import cpu_pipe_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          NREGS    = 32,
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] CNT_INIT = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [MEMWB_W-1:0]  wb_in,
    input  logic [ADDR_W-1:0]   rs_addr,
    input  logic [ADDR_W-1:0]   rt_addr,
    output logic [DATA_W-1:0]   rs_data,
    output logic [DATA_W-1:0]   rt_data,
    output logic                fwd_valid,
    output logic [ADDR_W-1:0]   fwd_reg,
    output logic [DATA_W-1:0]   fwd_data,
    output logic [31:0]         retire_cnt
);

    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_widx;
    logic              w_we;

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_fwd_valid;
    logic [ADDR_W-1:0] r_fwd_reg;
    logic [DATA_W-1:0] r_fwd_data;
    logic [31:0]       r_retire_cnt;

    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];

    wb_unpack #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_unpack (
        .i_bus   (wb_in),
        .o_wdata (w_wdata),
        .o_widx  (w_widx),
        .o_we    (w_we)
    );

    // w_we is never set for index 0, so r_regs[0] stays at its reset value.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_widx] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_fwd_valid  <= 1'b0;
            r_fwd_reg    <= '0;
            r_fwd_data   <= '0;
            r_retire_cnt <= CNT_INIT;
        end else begin
            r_fwd_valid <= w_we;
            if (w_we) begin
                r_fwd_reg    <= w_widx;
                r_fwd_data   <= w_wdata;
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign w_raddr[0] = rs_addr;
    assign w_raddr[1] = rt_addr;

    // Index 0 wins over the bypass so a write aimed at register 0 never leaks out.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign w_rdata[gi] =
                (w_raddr[gi] == ADDR_W'(REG_ZERO))   ? '0      :
                (w_we && (w_raddr[gi] == w_widx))    ? w_wdata :
                                                       r_regs[w_raddr[gi]];
        end
    endgenerate

    assign rs_data    = w_rdata[0];
    assign rt_data    = w_rdata[1];
    assign fwd_valid  = r_fwd_valid;
    assign fwd_reg    = r_fwd_reg;
    assign fwd_data   = r_fwd_data;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and model-checked bench for wb_regfile; a second instance with a
// preloaded retire counter exercises the 32-bit wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [71:0] wb_in  = '0;
    logic [71:0] wb_in2 = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;

    logic [31:0] rs_data, rt_data, fwd_data, retire_cnt;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;

    logic [31:0] rs_data2, rt_data2, fwd_data2, retire_cnt2;
    logic        fwd_valid2;
    logic [4:0]  fwd_reg2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .clr        (clr),
        .wb_in      (wb_in),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .fwd_valid  (fwd_valid),
        .fwd_reg    (fwd_reg),
        .fwd_data   (fwd_data),
        .retire_cnt (retire_cnt)
    );

    wb_regfile #(.CNT_INIT(32'hFFFF_FFFE)) dut_wrap (
        .clk        (clk),
        .clr        (clr),
        .wb_in      (wb_in2),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data2),
        .rt_data    (rt_data2),
        .fwd_valid  (fwd_valid2),
        .fwd_reg    (fwd_reg2),
        .fwd_data   (fwd_data2),
        .retire_cnt (retire_cnt2)
    );

    function automatic logic [71:0] mk(input logic rw, input logic m2r,
                                       input logic [5:0] wreg,
                                       input logic [31:0] alu,
                                       input logic [31:0] dm);
        return {dm, alu, wreg, m2r, rw};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int idx [3] = '{0, 1, 31};
        #1 clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            rs_addr = 5'(idx[k]);
            rt_addr = 5'(idx[k]);
            #1;
            checks++;
            if (rs_data !== 32'h0) begin errors++; $display("FAIL reset_rs[%0d]: got %h expected 00000000", idx[k], rs_data); end
            checks++;
            if (rt_data !== 32'h0) begin errors++; $display("FAIL reset_rt[%0d]: got %h expected 00000000", idx[k], rt_data); end
        end
        checks++;
        if (fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid: got %b expected 0", fwd_valid); end
        checks++;
        if (fwd_reg !== 5'd0) begin errors++; $display("FAIL reset_fwd_reg: got %0d expected 0", fwd_reg); end
        checks++;
        if (fwd_data !== 32'h0) begin errors++; $display("FAIL reset_fwd_data: got %h expected 00000000", fwd_data); end
        checks++;
        if (retire_cnt !== 32'h0) begin errors++; $display("FAIL reset_retire_cnt: got %h expected 00000000", retire_cnt); end
        checks++;
        if (retire_cnt2 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL reset_wrap_cnt: got %h expected fffffffe", retire_cnt2); end
        checks++;
        if ({fwd_valid2, fwd_reg2, fwd_data2, rs_data2, rt_data2} !== '0) begin
            errors++; $display("FAIL reset_wrap_state: got %b %0d %h %h %h expected all zero", fwd_valid2, fwd_reg2, fwd_data2, rs_data2, rt_data2);
        end
        clr = 1'b1;
        $display("txn reset: indices 0/1/31 read while clr low, released");
    endtask

    task automatic test_alu_wb();
        wb_in = mk(1'b1, 1'b0, 6'd8, 32'h1234_5678, 32'h0);
        tick();
        wb_in = '0;
        rs_addr = 5'd8;
        #1;
        checks++;
        if (rs_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_reg8: got %h expected 12345678", rs_data); end
        checks++;
        if (fwd_valid !== 1'b1) begin errors++; $display("FAIL alu_fwd_valid: got %b expected 1", fwd_valid); end
        checks++;
        if (fwd_reg !== 5'd8) begin errors++; $display("FAIL alu_fwd_reg: got %0d expected 8", fwd_reg); end
        checks++;
        if (fwd_data !== 32'h1234_5678) begin errors++; $display("FAIL alu_fwd_data: got %h expected 12345678", fwd_data); end
        checks++;
        if (retire_cnt !== 32'd1) begin errors++; $display("FAIL alu_cnt: got %0d expected 1", retire_cnt); end
        $display("txn alu_wb: reg8 <= 12345678");
        tick();
        checks++;
        if (fwd_valid !== 1'b0) begin errors++; $display("FAIL bubble_fwd_valid: got %b expected 0", fwd_valid); end
        checks++;
        if (fwd_reg !== 5'd8) begin errors++; $display("FAIL bubble_fwd_reg: got %0d expected 8", fwd_reg); end
        checks++;
        if (fwd_data !== 32'h1234_5678) begin errors++; $display("FAIL bubble_fwd_data: got %h expected 12345678", fwd_data); end
        checks++;
        if (retire_cnt !== 32'd1) begin errors++; $display("FAIL bubble_cnt: got %0d expected 1", retire_cnt); end
        $display("txn bubble: nothing committed");
    endtask

    task automatic test_load_bypass();
        wb_in = mk(1'b1, 1'b1, 6'd9, 32'h0000_0001, 32'hDEAD_BEEF);
        rs_addr = 5'd9;
        rt_addr = 5'd9;
        #1;
        checks++;
        if (rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rs: got %h expected deadbeef", rs_data); end
        checks++;
        if (rt_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rt: got %h expected deadbeef", rt_data); end
        tick();
        wb_in = '0;
        #1;
        checks++;
        if (rs_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_reg9: got %h expected deadbeef", rs_data); end
        checks++;
        if (fwd_reg !== 5'd9 || fwd_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL load_fwd: got %0d/%h expected 9/deadbeef", fwd_reg, fwd_data);
        end
        checks++;
        if (retire_cnt !== 32'd2) begin errors++; $display("FAIL load_cnt: got %0d expected 2", retire_cnt); end
        $display("txn load_wb: reg9 <= deadbeef (bypassed to both ports)");
    endtask

    task automatic test_reg0_reserved();
        wb_in = mk(1'b1, 1'b0, 6'd0, 32'hFFFF_FFFF, 32'h0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            errors++; $display("FAIL reg0_bypass: got %h/%h expected 00000000", rs_data, rt_data);
        end
        tick();
        checks++;
        if (rs_data !== 32'h0) begin errors++; $display("FAIL reg0_read: got %h expected 00000000", rs_data); end
        checks++;
        if (fwd_valid !== 1'b0 || fwd_reg !== 5'd9) begin
            errors++; $display("FAIL reg0_fwd: got %b/%0d expected 0/9", fwd_valid, fwd_reg);
        end
        checks++;
        if (retire_cnt !== 32'd2) begin errors++; $display("FAIL reg0_cnt: got %0d expected 2", retire_cnt); end
        $display("txn reg0: write to index 0 dropped");

        wb_in = mk(1'b1, 1'b0, 6'd5, 32'h0000_0055, 32'h0);
        tick();
        checks++;
        if (retire_cnt !== 32'd3) begin errors++; $display("FAIL reg5_cnt: got %0d expected 3", retire_cnt); end
        wb_in = mk(1'b1, 1'b0, 6'h25, 32'hAAAA_5555, 32'h0);
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        #1;
        checks++;
        if (rs_data !== 32'h0000_0055) begin errors++; $display("FAIL rsvd_bypass: got %h expected 00000055", rs_data); end
        tick();
        checks++;
        if (rt_data !== 32'h0000_0055) begin errors++; $display("FAIL rsvd_reg5: got %h expected 00000055", rt_data); end
        checks++;
        if (retire_cnt !== 32'd3 || fwd_valid !== 1'b0) begin
            errors++; $display("FAIL rsvd_cnt_fwd: got %0d/%b expected 3/0", retire_cnt, fwd_valid);
        end
        checks++;
        if (fwd_data !== 32'h0000_0055) begin errors++; $display("FAIL rsvd_fwd_data: got %h expected 00000055", fwd_data); end
        $display("txn reserved: writeReg=0x25 dropped, reg5 keeps 00000055");

        wb_in = mk(1'b0, 1'b0, 6'd5, 32'h0000_0077, 32'h0);
        #1;
        checks++;
        if (rs_data !== 32'h0000_0055) begin errors++; $display("FAIL norw_bypass: got %h expected 00000055", rs_data); end
        tick();
        wb_in = '0;
        checks++;
        if (rs_data !== 32'h0000_0055 || retire_cnt !== 32'd3) begin
            errors++; $display("FAIL norw_commit: got %h/%0d expected 00000055/3", rs_data, retire_cnt);
        end
        $display("txn no_regwrite: reg5 unchanged");
    endtask

    task automatic test_back_to_back();
        wb_in = mk(1'b1, 1'b0, 6'd10, 32'hA0A0_A0A0, 32'h0);
        tick();
        wb_in = mk(1'b1, 1'b1, 6'd10, 32'h0, 32'hB1B1_B1B1);
        rs_addr = 5'd10;
        rt_addr = 5'd11;
        #1;
        checks++;
        if (rs_data !== 32'hB1B1_B1B1) begin errors++; $display("FAIL b2b_overwrite_bypass: got %h expected b1b1b1b1", rs_data); end
        checks++;
        if (rt_data !== 32'h0) begin errors++; $display("FAIL b2b_rt11_empty: got %h expected 00000000", rt_data); end
        tick();
        wb_in = mk(1'b1, 1'b0, 6'd11, 32'hC2C2_C2C2, 32'hFFFF_0000);
        #1;
        checks++;
        if (rs_data !== 32'hB1B1_B1B1 || rt_data !== 32'hC2C2_C2C2) begin
            errors++; $display("FAIL b2b_reads: got %h/%h expected b1b1b1b1/c2c2c2c2", rs_data, rt_data);
        end
        checks++;
        if (fwd_reg !== 5'd10 || fwd_data !== 32'hB1B1_B1B1) begin
            errors++; $display("FAIL b2b_fwd1: got %0d/%h expected 10/b1b1b1b1", fwd_reg, fwd_data);
        end
        tick();
        wb_in = '0;
        #1;
        checks++;
        if (rt_data !== 32'hC2C2_C2C2 || fwd_reg !== 5'd11 || retire_cnt !== 32'd6) begin
            errors++; $display("FAIL b2b_final: got %h/%0d/%0d expected c2c2c2c2/11/6", rt_data, fwd_reg, retire_cnt);
        end
        $display("txn back_to_back: reg10 twice, reg11 once");
    endtask

    task automatic test_mid_reset();
        wb_in = mk(1'b1, 1'b0, 6'd3, 32'h0BAD_F00D, 32'h0);
        tick();
        checks++;
        if (retire_cnt !== 32'd7) begin errors++; $display("FAIL pre_reset_cnt: got %0d expected 7", retire_cnt); end
        wb_in = mk(1'b1, 1'b0, 6'd4, 32'h0000_0044, 32'h0);
        rs_addr = 5'd3;
        rt_addr = 5'd8;
        #2 clr = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            errors++; $display("FAIL async_clear_regs: got %h/%h expected 00000000", rs_data, rt_data);
        end
        checks++;
        if (retire_cnt !== 32'h0 || fwd_valid !== 1'b0 || fwd_reg !== 5'd0 || fwd_data !== 32'h0) begin
            errors++; $display("FAIL async_clear_state: got %0d/%b/%0d/%h expected 0/0/0/00000000", retire_cnt, fwd_valid, fwd_reg, fwd_data);
        end
        tick();
        @(negedge clk);
        clr = 1'b1;
        tick();
        wb_in = '0;
        rs_addr = 5'd3;
        rt_addr = 5'd4;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin errors++; $display("FAIL post_reset_reg3: got %h expected 00000000", rs_data); end
        checks++;
        if (rt_data !== 32'h0000_0044) begin errors++; $display("FAIL post_reset_reg4: got %h expected 00000044", rt_data); end
        checks++;
        if (retire_cnt !== 32'd1 || fwd_valid !== 1'b1 || fwd_reg !== 5'd4) begin
            errors++; $display("FAIL post_reset_fwd: got %0d/%b/%0d expected 1/1/4", retire_cnt, fwd_valid, fwd_reg);
        end
        rs_addr = 5'd8;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin errors++; $display("FAIL post_reset_reg8: got %h expected 00000000", rs_data); end
        $display("txn mid_reset: contents cleared, first post-release write committed");
    endtask

    task automatic test_wrap();
        wb_in2 = mk(1'b1, 1'b0, 6'd1, 32'h0000_0001, 32'h0);
        tick();
        checks++;
        if (retire_cnt2 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_max: got %h expected ffffffff", retire_cnt2); end
        tick();
        wb_in2 = '0;
        checks++;
        if (retire_cnt2 !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h expected 00000000", retire_cnt2); end
        tick();
        checks++;
        if (retire_cnt2 !== 32'h0) begin errors++; $display("FAIL wrap_hold: got %h expected 00000000", retire_cnt2); end
        $display("txn wrap: retire_cnt fffffffe -> ffffffff -> 00000000");
    endtask

    task automatic test_random();
        logic [31:0] m_regs [32];
        logic        m_fv;
        logic [4:0]  m_fr;
        logic [31:0] m_fd;
        logic [31:0] m_cnt;
        logic [95:0] rnd;
        logic        we;
        logic [4:0]  widx;
        logic [31:0] wdata, exp_rs, exp_rt;
        int          err0;

        err0 = errors;
        @(negedge clk);
        clr = 1'b0;
        #1 clr = 1'b1;
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_fv = 1'b0; m_fr = '0; m_fd = '0; m_cnt = '0;

        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            rnd   = {$urandom, $urandom, $urandom};
            wb_in = rnd[71:0];
            widx  = wb_in[6:2];
            wdata = wb_in[1] ? wb_in[71:40] : wb_in[39:8];
            we    = wb_in[0] && !wb_in[7] && (widx != 5'd0);
            rs_addr = ($urandom_range(3) == 0) ? widx : 5'($urandom);
            rt_addr = ($urandom_range(3) == 0) ? widx : 5'($urandom);
            exp_rs = (rs_addr == 5'd0) ? 32'h0 : (we && rs_addr == widx) ? wdata : m_regs[rs_addr];
            exp_rt = (rt_addr == 5'd0) ? 32'h0 : (we && rt_addr == widx) ? wdata : m_regs[rt_addr];
            #1;
            checks++;
            if (rs_data !== exp_rs) begin errors++; $display("FAIL rand_rs[%0d]: got %h expected %h", n, rs_data, exp_rs); end
            checks++;
            if (rt_data !== exp_rt) begin errors++; $display("FAIL rand_rt[%0d]: got %h expected %h", n, rt_data, exp_rt); end
            @(posedge clk);
            m_fv = we;
            if (we) begin
                m_regs[widx] = wdata;
                m_fr  = widx;
                m_fd  = wdata;
                m_cnt = m_cnt + 32'd1;
            end
            #1;
            checks++;
            if (fwd_valid !== m_fv) begin errors++; $display("FAIL rand_fwd_valid[%0d]: got %b expected %b", n, fwd_valid, m_fv); end
            checks++;
            if (fwd_reg !== m_fr) begin errors++; $display("FAIL rand_fwd_reg[%0d]: got %0d expected %0d", n, fwd_reg, m_fr); end
            checks++;
            if (fwd_data !== m_fd) begin errors++; $display("FAIL rand_fwd_data[%0d]: got %h expected %h", n, fwd_data, m_fd); end
            checks++;
            if (retire_cnt !== m_cnt) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", n, retire_cnt, m_cnt); end
        end
        wb_in = '0;
        $display("txn random: 10000 cycles, %0d commits, %0d new errors", m_cnt, errors - err0);
    endtask

    initial begin
        test_reset();
        test_alu_wb();
        test_load_bypass();
        test_reg0_reserved();
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded 2ms");
        $fatal(1, "timeout");
    end

endmodule
